// File: rtl/result_display.sv
// Captures an 8-bit result and converts it to BCD with shift-and-add-3 over 8 cycles.
// Drives a 4-digit multiplexed active-low seven-segment display with blanking and a minus sign.
module result_display #(
    parameter int WIDTH       = 8,
    parameter int REFRESH_DIV = 50000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] value,
    input  logic             neg,
    output logic             busy,
    output logic [6:0]       seg,
    output logic [3:0]       an,
    output logic             dp
);

    localparam int CW     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int ITER_W = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]     CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(WIDTH);

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_ZERO  = 7'b1000000;

    typedef enum logic {IDLE, CONVERT} state_t;

    function automatic logic [6:0] seg_code(input logic [3:0] d);
        case (d)
            4'd0:    seg_code = 7'b1000000;
            4'd1:    seg_code = 7'b1111001;
            4'd2:    seg_code = 7'b0100100;
            4'd3:    seg_code = 7'b0110000;
            4'd4:    seg_code = 7'b0011001;
            4'd5:    seg_code = 7'b0010010;
            4'd6:    seg_code = 7'b0000010;
            4'd7:    seg_code = 7'b1111000;
            4'd8:    seg_code = 7'b0000000;
            4'd9:    seg_code = 7'b0010000;
            default: seg_code = SEG_BLANK;
        endcase
    endfunction

    state_t              state_reg;
    logic [WIDTH-1:0]    shift_reg;
    logic [11:0]         bcd_reg;
    logic [11:0]         bcd_adj;
    logic [ITER_W-1:0]   iter_reg;
    logic                neg_reg;
    logic [6:0]          digit_reg [4];
    logic [CW-1:0]       cnt_reg;
    logic [1:0]          idx_reg;

    // Add-3 correction for each BCD nibble before it is shifted.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_adj
            assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                        bcd_reg[gi*4 +: 4] + 4'd3 : bcd_reg[gi*4 +: 4];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            busy         <= 1'b0;
            shift_reg    <= '0;
            bcd_reg      <= '0;
            iter_reg     <= '0;
            neg_reg      <= 1'b0;
            digit_reg[0] <= SEG_ZERO;
            digit_reg[1] <= SEG_BLANK;
            digit_reg[2] <= SEG_BLANK;
            digit_reg[3] <= SEG_BLANK;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (load) begin
                        shift_reg <= value;
                        neg_reg   <= neg;
                        bcd_reg   <= '0;
                        iter_reg  <= '0;
                        busy      <= 1'b1;
                        state_reg <= CONVERT;
                    end
                end
                CONVERT: begin
                    if (iter_reg == ITER_LAST) begin
                        // Interior zeros stay visible; only leading zeros blank.
                        digit_reg[0] <= seg_code(bcd_reg[3:0]);
                        digit_reg[1] <= (bcd_reg[11:4] == 8'd0) ? SEG_BLANK : seg_code(bcd_reg[7:4]);
                        digit_reg[2] <= (bcd_reg[11:8] == 4'd0) ? SEG_BLANK : seg_code(bcd_reg[11:8]);
                        digit_reg[3] <= neg_reg ? SEG_MINUS : SEG_BLANK;
                        busy         <= 1'b0;
                        state_reg    <= IDLE;
                    end else begin
                        {bcd_reg, shift_reg} <= {bcd_adj[10:0], shift_reg, 1'b0};
                        iter_reg             <= iter_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
            idx_reg <= 2'd0;
        end else if (cnt_reg == CNT_LAST) begin
            cnt_reg <= '0;
            idx_reg <= idx_reg + 2'd1;
        end else begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    // Pure decode of registered state, so a digit update shows on the current digit at once.
    always_comb begin
        an  = ~(4'b0001 << idx_reg);
        seg = digit_reg[idx_reg];
        dp  = 1'b1;
    end

endmodule

// File: tb/tb_result_display.sv
// Randomized bench for result_display with a cycle-level reference model using
// decimal arithmetic for digits and elapsed-cycle arithmetic for the scanner.
module tb_result_display;

    localparam int RD = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       load = 1'b0;
    logic [7:0] value = 8'd0;
    logic       neg = 1'b0;
    logic       busy;
    logic [6:0] seg;
    logic [3:0] an;
    logic       dp;

    int checks = 0;
    int failures = 0;

    int         cyc;
    int         pend;
    int         pv;
    bit         pn;
    logic [6:0] exp_dig [4];

    result_display #(.WIDTH(8), .REFRESH_DIV(RD)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value), .neg(neg),
        .busy(busy), .seg(seg), .an(an), .dp(dp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] code_of(input int d);
        case (d)
            0: return 7'b1000000;  1: return 7'b1111001;
            2: return 7'b0100100;  3: return 7'b0110000;
            4: return 7'b0011001;  5: return 7'b0010010;
            6: return 7'b0000010;  7: return 7'b1111000;
            8: return 7'b0000000;  9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic set_digits(input int v, input bit n);
        int h, t, o;
        h = v / 100;
        t = (v / 10) % 10;
        o = v % 10;
        exp_dig[0] = code_of(o);
        exp_dig[1] = (h == 0 && t == 0) ? 7'b1111111 : code_of(t);
        exp_dig[2] = (h == 0) ? 7'b1111111 : code_of(h);
        exp_dig[3] = n ? 7'b0111111 : 7'b1111111;
        $display("txn value=%0d neg=%0d digits=%b %b %b %b", v, n,
                 exp_dig[3], exp_dig[2], exp_dig[1], exp_dig[0]);
    endtask

    task automatic reset_model();
        cyc = 0;
        pend = 0;
        exp_dig[0] = 7'b1000000;
        exp_dig[1] = 7'b1111111;
        exp_dig[2] = 7'b1111111;
        exp_dig[3] = 7'b1111111;
    endtask

    task automatic check_scan(input string tag);
        int i;
        logic [3:0] ea;
        i = (cyc / RD) % 4;
        ea = 4'b1111;
        ea[i] = 1'b0;
        check({tag, "_an"}, 32'(an), 32'(ea));
        check({tag, "_seg"}, 32'(seg), 32'(exp_dig[i]));
        check({tag, "_busy"}, 32'(busy), 32'(pend > 0));
        check({tag, "_dp"}, 32'(dp), 32'd1);
    endtask

    // One clock: advance the model on the edge, then compare 1 time unit later.
    task automatic tick(input string tag);
        @(posedge clk);
        if (rst_n) begin
            cyc++;
            if (pend > 0) begin
                pend--;
                if (pend == 0) set_digits(pv, pn);
            end else if (load) begin
                pend = 9;
                pv = int'(value);
                pn = neg;
            end
        end
        #1;
        check_scan(tag);
    endtask

    task automatic do_reset(input int hold);
        rst_n = 1'b0;
        reset_model();
        #1;
        check_scan("rst");
        repeat (hold) begin
            @(posedge clk);
            #1;
            check_scan("rst_hold");
        end
        rst_n = 1'b1;
    endtask

    task automatic run_load(input int v, input bit n, input int after);
        load = 1'b1;
        value = 8'(v);
        neg = n;
        tick("load");
        load = 1'b0;
        repeat (9 + after) begin
            value = 8'($urandom);
            neg = 1'($urandom);
            tick("conv");
        end
    endtask

    initial begin
        reset_model();
        #2;
        do_reset(3);
        repeat (20) tick("scan_rst");

        run_load(255, 0, 16);
        run_load(7, 1, 16);
        run_load(0, 0, 16);
        run_load(105, 0, 16);
        run_load(40, 0, 16);

        // Loads during a conversion, including on the completion edge, are ignored.
        load = 1'b1; value = 8'd200; neg = 1'b0;
        tick("ld200");
        load = 1'b0;
        repeat (2) tick("c200");
        load = 1'b1; value = 8'd99;
        tick("ign3");
        load = 1'b0;
        repeat (5) tick("c200");
        load = 1'b1; value = 8'd99;
        tick("ign9");
        check("done200", 32'(seg === exp_dig[(cyc / RD) % 4]), 32'd1);
        tick("acc10");
        load = 1'b0;
        repeat (24) tick("c99");

        // Reset in the middle of a conversion aborts it.
        load = 1'b1; value = 8'd123; neg = 1'b0;
        tick("ld123");
        load = 1'b0;
        repeat (4) tick("c123");
        do_reset(2);
        repeat (3) tick("post_rst");
        run_load(123, 0, 16);

        for (int k = 0; k < 40; k++) begin
            load = 1'b1;
            value = 8'($urandom);
            neg = 1'($urandom);
            tick("rnd_ld");
            load = 1'b0;
            for (int g = 0; g < int'($urandom_range(0, 14)); g++) begin
                value = 8'($urandom);
                neg = 1'($urandom);
                load = ($urandom_range(0, 3) == 0);
                tick("rnd");
            end
            load = 1'b0;
        end
        repeat (12) tick("tail");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
